// File: rtl/pret_et.sv
// pret_et: precision-adaptive stochastic encoder / early-terminating counter.
//
// A run converts N binary operands into N stochastic bit streams using a
// bit-reversed counter as the random source, and accumulates an external
// stochastic result bit Z into a ones-count. The run normally lasts 2^p
// cycles. A stop request cuts it short at the next count c where c+1 is a
// power of two, so the accumulated result is always scaled from a complete
// 2^pe-sample window.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a run (only honoured in IDLE)
//   prec         requested precision p (clamped to W); run is 2^p cycles
//   stop         early-termination request (held until the run ends)
//   Bxs          N binary operands, W bits each
//   X            N stochastic bits, zero outside a run
//   Z            external stochastic result bit for the current X
//   Bz           result scaled to W fractional bits (W+1 wide, holds 2^W)
//   p_eff        precision actually achieved by the last run
//   busy, done   run active / one-cycle completion pulse

// Per-channel stochastic number generator: compares the latched operand
// against a bit-reversed (optionally index-permuted) copy of the counter.
module pret_et_lane #(
    parameter int W    = 8,
    parameter int CORR = 0,
    parameter int IDX  = 0
) (
    input  logic         run,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] c,
    input  logic [W-1:0] mask,
    output logic         x
);
    logic [W-1:0] idx;
    logic [W-1:0] sel;
    logic [W-1:0] r;

    assign idx = W'(IDX);
    // Only the low p bits of the index are mixed in so that every lane still
    // sweeps exactly the same set of 2^p counter values within the run.
    assign sel = (CORR != 0) ? c : (c ^ (idx & mask));

    always_comb begin
        r = '0;
        for (int j = 0; j < W; j++) r[j] = sel[W-1-j];
    end

    assign x = run & (bx > r);
endmodule

module pret_et #(
    parameter int W    = 8,
    parameter int N    = 8,
    parameter int CORR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(W+1)-1:0]     prec,
    input  logic                       stop,
    input  logic [N-1:0][W-1:0]        Bxs,
    output logic [N-1:0]               X,
    input  logic                       Z,
    output logic [W:0]                 Bz,
    output logic [$clog2(W+1)-1:0]     p_eff,
    output logic                       busy,
    output logic                       done
);
    localparam int PW = $clog2(W+1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [N-1:0][W-1:0]    bx_q;
    logic [PW-1:0]          p_q;
    logic [W-1:0]           c;
    logic [W-1:0]           c_inc;
    logic [W:0]             k;
    logic [W:0]             k_fin;
    logic                   stop_q;
    logic [W-1:0]           mask;
    logic [PW-1:0]          pe;
    logic                   at_bound;
    logic                   at_window;
    logic                   term;
    logic [PW-1:0]          p_clamp;

    assign p_clamp = (prec > PW'(W)) ? PW'(W) : prec;

    // mask = 2^p - 1, built bitwise so p = W needs no wider intermediate
    always_comb begin
        mask = '0;
        for (int j = 0; j < W; j++) mask[j] = (PW'(j) < p_q);
    end

    // At termination c+1 is a power of two, so c is all-ones in its low
    // bits and log2(c+1) is simply its popcount.
    always_comb begin
        pe = '0;
        for (int j = 0; j < W; j++) pe = pe + PW'(c[j]);
    end

    assign c_inc     = c + W'(1);
    assign at_bound  = (c == mask);
    // c+1 is a power of two; c = all-ones wraps c_inc to 0 and still qualifies
    assign at_window = ((c & c_inc) == '0);
    assign term      = at_bound | ((stop | stop_q) & at_window);
    // final cycle's Z is folded in here rather than into k
    assign k_fin     = k + (W+1)'(Z);

    for (genvar i = 0; i < N; i++) begin : g_lane
        pret_et_lane #(.W(W), .CORR(CORR), .IDX(i)) u_lane (
            .run  (state == RUN),
            .bx   (bx_q[i]),
            .c    (c),
            .mask (mask),
            .x    (X[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            bx_q   <= '0;
            p_q    <= '0;
            c      <= '0;
            k      <= '0;
            stop_q <= 1'b0;
            Bz     <= '0;
            p_eff  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bx_q   <= Bxs;
                        p_q    <= p_clamp;
                        c      <= '0;
                        k      <= '0;
                        stop_q <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (term) begin
                        Bz     <= k_fin << (PW'(W) - pe);
                        p_eff  <= pe;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        stop_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        c <= c_inc;
                        k <= k_fin;
                        if (stop) stop_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pret_et.sv
module tb_pret_et;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop;
    logic [3:0]       prec;
    logic [1:0][7:0]  Bxs;
    logic [1:0]       x1, x0;
    logic             z1, z0;
    logic [8:0]       bz1, bz0;
    logic [3:0]       pe1, pe0;
    logic             busy1, busy0, done1, done0;
    int               zmode;

    typedef struct {int cycles; int bz; int pe;} exp_t;
    exp_t       sb[$];
    logic [1:0] xs1[$];
    logic [1:0] xs0[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         run_cycles;
    logic       done_end;

    always #5 clk = ~clk;

    assign z1 = (zmode == 0) ? x1[0] : (zmode == 1);
    assign z0 = (zmode == 0) ? x0[0] : (zmode == 1);

    pret_et #(.W(8), .N(2), .CORR(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prec(prec), .stop(stop),
        .Bxs(Bxs), .X(x1), .Z(z1), .Bz(bz1), .p_eff(pe1), .busy(busy1), .done(done1));

    pret_et #(.W(8), .N(2), .CORR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .prec(prec), .stop(stop),
        .Bxs(Bxs), .X(x0), .Z(z0), .Bz(bz0), .p_eff(pe0), .busy(busy0), .done(done0));

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = v[7-j];
        return r;
    endfunction

    // Cycle-by-cycle reference for channel 0 of the correlated instance.
    function automatic exp_t model(input logic [7:0] bx, input int pr, input int zm, input int stop_c);
        exp_t e;
        int p, k, c, pe;
        logic x, z;
        p = (pr > 8) ? 8 : pr;
        k = 0;
        c = 0;
        while (1) begin
            x = bx > rev8(c[7:0]);
            z = (zm == 0) ? x : (zm == 1);
            k += int'(z);
            if (c == (1 << p) - 1) break;
            if (c >= stop_c && ((c + 1) & c) == 0) break;
            c++;
        end
        pe = 0;
        while ((1 << pe) < c + 1) pe++;
        e.cycles = c + 1;
        e.bz = k << (8 - pe);
        e.pe = pe;
        return e;
    endfunction

    // Drives one run from a negedge; returns at the negedge after termination.
    task automatic do_run(input logic [7:0] b0, input logic [7:0] b1, input int pr,
                          input int zm, input int stop_c, input int inj);
        Bxs[0] = b0; Bxs[1] = b1; prec = pr[3:0]; zmode = zm; start = 1'b1;
        xs1.delete(); xs0.delete();
        @(negedge clk);
        start = 1'b0;
        run_cycles = 0;
        while (busy1 && run_cycles < 600) begin
            stop  = (run_cycles == stop_c);
            start = (run_cycles == inj);
            xs1.push_back(x1);
            xs0.push_back(x0);
            run_cycles++;
            @(negedge clk);
        end
        stop = 1'b0; start = 1'b0;
        done_end = done1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; stop = 0; prec = 0; Bxs = '0; zmode = 2;
        repeat (2) @(negedge clk);
        n_cmp++; if (x1 !== 2'b00)  begin n_bad++; $display("FAIL reset_x: got %b want 00", x1); end
        n_cmp++; if (bz1 !== 9'd0)  begin n_bad++; $display("FAIL reset_bz: got %0d want 0", bz1); end
        n_cmp++; if (pe1 !== 4'd0)  begin n_bad++; $display("FAIL reset_pe: got %0d want 0", pe1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
        n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done1); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_runs;
        logic [7:0] bx[3] = '{8'h80, 8'hFF, 8'hFF};
        int zm[3]  = '{0, 1, 0};
        int ebz[3] = '{128, 256, 255};
        exp_t e;
        logic da;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{256, ebz[i], 8});
            do_run(bx[i], 8'h00, 8, zm[i], 1000, -1);
            da = done1;
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++; if (run_cycles != e.cycles) begin n_bad++; $display("FAIL full%0d_cycles: got %0d want %0d", i, run_cycles, e.cycles); end
            n_cmp++; if (bz1 !== 9'(e.bz)) begin n_bad++; $display("FAIL full%0d_bz: got %0d want %0d", i, bz1, e.bz); end
            n_cmp++; if (pe1 !== 4'(e.pe)) begin n_bad++; $display("FAIL full%0d_pe: got %0d want %0d", i, pe1, e.pe); end
            n_cmp++; if ({done_end, done1, da} !== 3'b101) begin n_bad++; $display("FAIL full%0d_done: got %b want 101", i, {done_end, done1, da}); end
        end
    endtask

    task automatic test_short_seq;
        logic [3:0] pat = 4'b0101;
        exp_t e;
        sb.push_back('{4, 128, 2});
        do_run(8'h60, 8'h00, 2, 0, 1000, -1);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (run_cycles != e.cycles) begin n_bad++; $display("FAIL short_cycles: got %0d want %0d", run_cycles, e.cycles); end
        n_cmp++; if (bz1 !== 9'(e.bz)) begin n_bad++; $display("FAIL short_bz: got %0d want %0d", bz1, e.bz); end
        n_cmp++; if (pe1 !== 4'(e.pe)) begin n_bad++; $display("FAIL short_pe: got %0d want %0d", pe1, e.pe); end
        for (int i = 0; i < 4 && i < xs1.size(); i++) begin
            n_cmp++; if (xs1[i][0] !== pat[i]) begin n_bad++; $display("FAIL short_x0[%0d]: got %b want %b", i, xs1[i][0], pat[i]); end
        end
    endtask

    task automatic test_stop;
        int sc[2] = '{2, 0};
        int ec[2] = '{4, 1};
        int ep[2] = '{2, 0};
        exp_t e, m;
        // stop in IDLE must not carry into the next run
        stop = 1'b1;
        repeat (2) @(negedge clk);
        stop = 1'b0;
        sb.push_back('{4, 128, 2});
        do_run(8'h80, 8'h00, 2, 0, 1000, -1);
        e = sb.pop_front();
        n_cmp++; if (run_cycles != e.cycles) begin n_bad++; $display("FAIL idle_stop_cycles: got %0d want %0d", run_cycles, e.cycles); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m = model(8'h80, 8, 0, sc[i]);
            sb.push_back('{ec[i], m.bz, ep[i]});
            do_run(8'h80, 8'h00, 8, 0, sc[i], -1);
            e = sb.pop_front();
            n_cmp++; if (run_cycles != e.cycles) begin n_bad++; $display("FAIL stop%0d_cycles: got %0d want %0d", i, run_cycles, e.cycles); end
            n_cmp++; if (bz1 !== 9'(e.bz)) begin n_bad++; $display("FAIL stop%0d_bz: got %0d want %0d", i, bz1, e.bz); end
            n_cmp++; if (pe1 !== 4'(e.pe)) begin n_bad++; $display("FAIL stop%0d_pe: got %0d want %0d", i, pe1, e.pe); end
        end
    endtask

    task automatic test_prec_edges;
        int pr[3]  = '{0, 0, 15};
        int zm[3]  = '{1, 2, 0};
        int inj[3] = '{-1, -1, 5};
        exp_t e;
        sb.push_back('{1, 256, 0});
        sb.push_back('{1, 0, 0});
        sb.push_back(model(8'h40, 15, 0, 1000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            do_run(8'h40, 8'h00, pr[i], zm[i], 1000, inj[i]);
            e = sb.pop_front();
            n_cmp++; if (run_cycles != e.cycles) begin n_bad++; $display("FAIL prec%0d_cycles: got %0d want %0d", i, run_cycles, e.cycles); end
            n_cmp++; if (bz1 !== 9'(e.bz)) begin n_bad++; $display("FAIL prec%0d_bz: got %0d want %0d", i, bz1, e.bz); end
            n_cmp++; if (pe1 !== 4'(e.pe)) begin n_bad++; $display("FAIL prec%0d_pe: got %0d want %0d", i, pe1, e.pe); end
        end
    endtask

    task automatic test_corr;
        logic [3:0] p0 = 4'b0101;
        logic [3:0] p1 = 4'b1010;
        @(negedge clk);
        do_run(8'h80, 8'h80, 2, 0, 1000, -1);
        n_cmp++; if (xs0.size() != 4) begin n_bad++; $display("FAIL corr_len: got %0d want 4", xs0.size()); end
        for (int i = 0; i < 4 && i < xs0.size(); i++) begin
            n_cmp++; if (xs0[i] !== {p1[i], p0[i]}) begin n_bad++; $display("FAIL corr0_x[%0d]: got %b want %b", i, xs0[i], {p1[i], p0[i]}); end
            n_cmp++; if (xs1[i] !== {p0[i], p0[i]}) begin n_bad++; $display("FAIL corr1_x[%0d]: got %b want %b", i, xs1[i], {p0[i], p0[i]}); end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        @(negedge clk);
        sb.push_back(model(8'hC0, 1, 0, 1000));
        sb.push_back(model(8'h30, 2, 0, 1000));
        do_run(8'hC0, 8'h00, 1, 0, 1000, -1);
        e = sb.pop_front();
        n_cmp++; if (run_cycles != e.cycles || done_end !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got %0d/%b want %0d/1", run_cycles, done_end, e.cycles); end
        // new start issued in the done cycle
        do_run(8'h30, 8'h00, 2, 0, 1000, -1);
        e = sb.pop_front();
        n_cmp++; if (run_cycles != e.cycles) begin n_bad++; $display("FAIL b2b_cycles: got %0d want %0d", run_cycles, e.cycles); end
        n_cmp++; if (bz1 !== 9'(e.bz)) begin n_bad++; $display("FAIL b2b_bz: got %0d want %0d", bz1, e.bz); end
    endtask

    task automatic test_reset_mid;
        logic saw_done = 1'b0;
        exp_t e;
        @(negedge clk);
        Bxs[0] = 8'h80; prec = 4'd8; zmode = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy1, done1, x1, x0} !== 6'b0) begin n_bad++; $display("FAIL midrst_ctl: got %b want 000000", {busy1, done1, x1, x0}); end
        n_cmp++; if (bz1 !== 9'd0 || pe1 !== 4'd0) begin n_bad++; $display("FAIL midrst_out: got %0d/%0d want 0/0", bz1, pe1); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_done |= done1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_done |= done1 | busy1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL midrst_nodone: got %b want 0", saw_done); end
        sb.push_back(model(8'h80, 1, 0, 1000));
        do_run(8'h80, 8'h00, 1, 0, 1000, -1);
        e = sb.pop_front();
        n_cmp++; if (run_cycles != e.cycles || bz1 !== 9'(e.bz)) begin n_bad++; $display("FAIL post_rst_run: got %0d/%0d want %0d/%0d", run_cycles, bz1, e.cycles, e.bz); end
    endtask

    task automatic test_random;
        logic [7:0] b;
        int pr, zm, sc;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            b  = 8'($urandom);
            pr = $urandom_range(0, 8);
            zm = $urandom_range(0, 2);
            sc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : 1000;
            @(negedge clk);
            sb.push_back(model(b, pr, zm, sc));
            do_run(b, 8'h00, pr, zm, sc, -1);
            e = sb.pop_front();
            n_cmp++; if (run_cycles != e.cycles || bz1 !== 9'(e.bz) || pe1 !== 4'(e.pe)) begin
                n_bad++;
                $display("FAIL rand%0d (bx=%h p=%0d z=%0d s=%0d): got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, b, pr, zm, sc, run_cycles, bz1, pe1, e.cycles, e.bz, e.pe);
            end
        end
    endtask

    initial begin
        test_reset;
        test_full_runs;
        test_short_seq;
        test_stop;
        test_prec_edges;
        test_corr;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
